// File: rtl/uart_rx_fifo.sv
// Asynchronous serial receiver with per-frame parity/framing checks, feeding a
// show-ahead FIFO whose entries carry the data word plus its two error flags.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset,
    input  logic                          rxd,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bits,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_valid,
    output logic                          rd_parity_err,
    output logic                          rd_frame_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned ENT_W  = DATA_BITS + 2;

    localparam logic [CNT_W-1:0]  HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_BITS - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT = FCNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_meta;
    logic                 rx_sync;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift;
    logic [1:0]           mode_q;
    logic                 two_stop_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 tick_half;
    logic                 tick_full;
    logic                 parity_on;
    logic                 push;
    logic                 push_frame_err;

    assign tick_half = (baud_cnt == HALF_CNT);
    assign tick_full = (baud_cnt == LAST_CNT);
    assign parity_on = (mode_q == 2'b01) || (mode_q == 2'b10);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        push           = 1'b0;
        // The sampled stop bit is folded in directly so the push needs no extra cycle.
        push_frame_err = frame_err_q | ~rx_sync;
        case (state)
            IDLE:   if (!rx_sync) state_next = START;
            START:  if (tick_half) state_next = rx_sync ? IDLE : DATA;
            DATA:   if (tick_full && bit_idx == LAST_BIT) state_next = parity_on ? PARITY : STOP1;
            PARITY: if (tick_full) state_next = STOP1;
            STOP1: begin
                if (tick_full) begin
                    if (two_stop_q) begin
                        state_next = STOP2;
                    end else begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            STOP2: begin
                if (tick_full) begin
                    push       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_meta      <= 1'b1;
            rx_sync      <= 1'b1;
            baud_cnt     <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            mode_q       <= '0;
            two_stop_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta <= rxd;
            rx_sync <= rx_meta;

            if (state == IDLE || (state == START && tick_half) || tick_full) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        mode_q       <= parity_mode;
                        two_stop_q   <= stop_bits;
                        parity_err_q <= 1'b0;
                        frame_err_q  <= 1'b0;
                        bit_idx      <= '0;
                    end
                end
                DATA: begin
                    if (tick_full) begin
                        shift   <= {rx_sync, shift[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
                PARITY: begin
                    if (tick_full) parity_err_q <= ((^shift) ^ rx_sync) != (mode_q == 2'b10);
                end
                STOP1: begin
                    if (tick_full) frame_err_q <= ~rx_sync;
                end
                default: ;
            endcase
        end
    end

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] count;
    logic [ENT_W-1:0]  head;
    logic              do_pop;
    logic              do_push;
    logic              drop;

    assign do_pop  = rd_en && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign drop    = push && !do_push;

    always_ff @(posedge clk_clk) begin
        if (do_push) mem[wr_ptr] <= {parity_err_q, push_frame_err, shift};
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + FCNT_W'(1);
                2'b01:   count <= count - FCNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Head is masked while empty so the outputs read zero out of reset.
    assign head          = mem[rd_ptr];
    assign rd_valid      = (count != '0);
    assign rd_data       = rd_valid ? head[DATA_BITS-1:0] : '0;
    assign rd_frame_err  = rd_valid ? head[DATA_BITS] : 1'b0;
    assign rd_parity_err = rd_valid ? head[DATA_BITS+1] : 1'b0;
    assign fifo_count    = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboarded bench for uart_rx_fifo: frames are described at field level, the
// expected FIFO entry is derived from the frame rules and checked as the DUT presents it.
module tb_uart_rx_fifo;

    localparam int unsigned DB    = 8;
    localparam int unsigned CPB   = 16;
    localparam int unsigned DEPTH = 4;

    logic          clk_clk = 1'b0;
    logic          reset_reset = 1'b1;
    logic          rxd = 1'b1;
    logic [1:0]    parity_mode = 2'b00;
    logic          stop_bits = 1'b0;
    logic          rd_en = 1'b0;
    logic [DB-1:0] rd_data;
    logic          rd_valid;
    logic          rd_parity_err;
    logic          rd_frame_err;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          clr_overflow = 1'b0;

    uart_rx_fifo #(
        .DATA_BITS   (DB),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .rxd          (rxd),
        .parity_mode  (parity_mode),
        .stop_bits    (stop_bits),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_parity_err(rd_parity_err),
        .rd_frame_err (rd_frame_err),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct packed {
        logic [DB-1:0] data;
        logic          perr;
        logic          ferr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   reads_on = 1'b0;
    bit   exp_ovf = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference model: entry contents follow from the frame fields alone.
    task automatic expect_frame(input logic [DB-1:0] d, input logic [1:0] mode, input logic two,
                                input logic pbit, input logic s1, input logic s2);
        exp_t e;
        e.data = d;
        e.perr = (mode == 2'b01 || mode == 2'b10) ? (((^d) ^ pbit) != (mode == 2'b10)) : 1'b0;
        e.ferr = !s1 || (two && !s2);
        if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
        else exp_q.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk_clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic [1:0] mode, input logic two,
                              input logic pbit, input logic s1, input logic s2, input bit scramble);
        parity_mode = mode;
        stop_bits   = two;
        expect_frame(d, mode, two, pbit, s1, s2);
        send_bit(1'b0);
        if (scramble) begin
            parity_mode = 2'($urandom);
            stop_bits   = 1'($urandom);
        end
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (mode == 2'b01 || mode == 2'b10) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk_clk);
    endtask

    task automatic drain();
        reads_on = 1'b1;
        for (int i = 0; i < 400 && (exp_q.size() != 0 || rd_valid); i++) @(negedge clk_clk);
        repeat (3) @(negedge clk_clk);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);
        check("drain_fifo_count", 32'(fifo_count), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        reads_on = 1'b0;
    endtask

    // Monitor: pops and compares whenever reads are enabled and the FIFO shows a word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_clk);
            if (reads_on && !reset_reset && rd_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: actual data=%0h required no entry", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e.data));
                    check("rd_parity_err", 32'(rd_parity_err), 32'(e.perr));
                    check("rd_frame_err", 32'(rd_frame_err), 32'(e.ferr));
                end
                rd_en = 1'b1;
                @(negedge clk_clk);
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk_clk);
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "cycle budget exhausted");
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
        check({tag, "_rd_parity_err"}, 32'(rd_parity_err), 32'd0);
        check({tag, "_rd_frame_err"}, 32'(rd_frame_err), 32'd0);
        check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        logic [DB-1:0] d;
        logic [1:0]    m;
        logic          two;
        logic          pbit;
        logic          s1;
        logic          s2;

        repeat (4) @(negedge clk_clk);
        check_reset_values("reset");
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);

        // Basic frame, inspected before and after a single pop.
        send_frame(8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("a5_rd_valid", 32'(rd_valid), 32'd1);
        check("a5_fifo_count", 32'(fifo_count), 32'd1);
        check("a5_rd_data", 32'(rd_data), 32'hA5);
        check("a5_errs", 32'({rd_parity_err, rd_frame_err}), 32'd0);
        drain();

        // Parity: same data and parity bit under even then odd mode.
        send_frame(8'h03, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("even_parity_err", 32'(rd_parity_err), 32'd1);
        drain();
        send_frame(8'h03, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("odd_parity_err", 32'(rd_parity_err), 32'd0);
        drain();

        // False start: short low pulse must not push, and the receiver must recover.
        rxd = 1'b0;
        repeat (4) @(negedge clk_clk);
        rxd = 1'b1;
        repeat (3 * CPB) @(negedge clk_clk);
        check("false_start_count", 32'(fifo_count), 32'd0);
        check("false_start_valid", 32'(rd_valid), 32'd0);
        send_frame(8'h3C, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        drain();

        // Two stop bits with the second one low.
        send_frame(8'h5A, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("two_stop_frame_err", 32'(rd_frame_err), 32'd1);
        drain();

        // Overflow: five frames into a four-entry FIFO with no reads.
        for (int i = 1; i <= 5; i++) send_frame(DB'(8'h11 * i), 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_overflow", 32'(overflow), 32'(exp_ovf));
        check("ovf_head", 32'(rd_data), 32'h11);
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk_clk);
        clr_overflow = 1'b0;
        exp_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(exp_ovf));

        // Reset in the middle of a frame with one word stored.
        send_frame(8'h42, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pre_reset_count", 32'(fifo_count), 32'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        reset_reset = 1'b1;
        rxd = 1'b1;
        exp_q.delete();
        @(negedge clk_clk);
        check_reset_values("midframe_reset");
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        send_frame(8'h88, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("post_reset_count", 32'(fifo_count), 32'd1);
        check("post_reset_head", 32'(rd_data), 32'h88);
        drain();

        // Randomised frames with reads enabled and config inputs scrambled mid-frame.
        reads_on = 1'b1;
        for (int n = 0; n < 25; n++) begin
            d    = DB'($urandom);
            m    = 2'($urandom);
            two  = 1'($urandom);
            pbit = ((m == 2'b10) ? ~(^d) : (^d)) ^ ($urandom_range(0, 3) == 0);
            s1   = ($urandom_range(0, 5) != 0);
            s2   = ($urandom_range(0, 5) != 0);
            send_frame(d, m, two, pbit, s1, s2, 1'b1);
        end
        drain();
        check("final_overflow", 32'(overflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
